// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one combinational ALU: grants at most one requester per
// cycle, forwards its operation to the ALU and buffers one result per port.
module alu_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_funct3,
  input  logic [6:0]  req0_funct7,
  input  logic        req0_src_sel,
  input  logic [31:0] req0_op_a,
  input  logic [31:0] req0_rs2,
  input  logic [31:0] req0_imm,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_funct3,
  input  logic [6:0]  req1_funct7,
  input  logic        req1_src_sel,
  input  logic [31:0] req1_op_a,
  input  logic [31:0] req1_rs2,
  input  logic [31:0] req1_imm,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  output logic        alu_src_sel,
  output logic        alu_en,
  output logic [31:0] alu_reg_data_1,
  output logic [31:0] alu_reg_data_2,
  output logic [31:0] alu_immediate,
  input  logic [31:0] alu_res
);

  logic        last_grant_q, last_grant_d;
  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic [31:0] rsp0_data_q, rsp0_data_d;
  logic [31:0] rsp1_data_q, rsp1_data_d;
  logic        elig0, elig1, gnt0, gnt1;

  // rst_n gates eligibility so grants and ALU outputs drop the moment reset asserts.
  always_comb begin
    elig0 = rst_n && req0_valid && (!rsp0_valid_q || rsp0_ready) && !flush;
    elig1 = rst_n && req1_valid && (!rsp1_valid_q || rsp1_ready) && !flush;
    if (FAIR) begin
      gnt0 = elig0 && (!elig1 || last_grant_q);
    end else begin
      gnt0 = elig0;
    end
    gnt1 = elig1 && !gnt0;
  end

  always_comb begin
    alu_en         = gnt0 || gnt1;
    alu_funct3     = '0;
    alu_funct7     = '0;
    alu_src_sel    = 1'b0;
    alu_reg_data_1 = '0;
    alu_reg_data_2 = '0;
    alu_immediate  = '0;
    if (gnt0) begin
      alu_funct3     = req0_funct3;
      alu_funct7     = req0_funct7;
      alu_src_sel    = req0_src_sel;
      alu_reg_data_1 = req0_op_a;
      alu_reg_data_2 = req0_rs2;
      alu_immediate  = req0_imm;
    end else if (gnt1) begin
      alu_funct3     = req1_funct3;
      alu_funct7     = req1_funct7;
      alu_src_sel    = req1_src_sel;
      alu_reg_data_1 = req1_op_a;
      alu_reg_data_2 = req1_rs2;
      alu_immediate  = req1_imm;
    end
  end

  // A grant never coincides with flush, so flush only has to clear the valids.
  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt0) begin
      last_grant_d = 1'b0;
    end else if (gnt1) begin
      last_grant_d = 1'b1;
    end
    rsp0_valid_d = rsp0_valid_q;
    rsp0_data_d  = rsp0_data_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_data_d  = rsp1_data_q;
    if (flush) begin
      rsp0_valid_d = 1'b0;
      rsp1_valid_d = 1'b0;
    end else begin
      if (gnt0) begin
        rsp0_valid_d = 1'b1;
        rsp0_data_d  = alu_res;
      end else if (rsp0_ready) begin
        rsp0_valid_d = 1'b0;
      end
      if (gnt1) begin
        rsp1_valid_d = 1'b1;
        rsp1_data_d  = alu_res;
      end else if (rsp1_ready) begin
        rsp1_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;

endmodule
